// File: rtl/reg_file_pkg.sv
// Shared definitions for the datapath register file: default geometry,
// the hardwired-zero address and the default data word type.
package reg_file_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_DEPTH = 16;
  localparam int ZERO_ADDR     = 0;

  typedef logic [DEFAULT_WIDTH-1:0] word_t;

endpackage

// File: rtl/reg_file_cell.sv
// One register-file entry: WIDTH-bit data register plus a "written since
// reset" flag, synchronous active-low reset taking priority over write.
module reg_file_cell
  import reg_file_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             write,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] data,
  output logic             written
);

  always_ff @(posedge clock) begin
    if (!reset) begin
      data    <= '0;
      written <= 1'b0;
    end else if (write) begin
      data    <= wdata;
      written <= 1'b1;
    end
  end

endmodule

// File: rtl/reg_file.sv
// DEPTH x WIDTH register file, one write port, two combinational read ports.
// Define REG_FILE_BYPASS_EN to forward same-cycle write data to matching reads.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int ZERO_REG = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              write,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [WIDTH-1:0]  rdata_a,
  output logic [WIDTH-1:0]  rdata_b,
  output logic              valid_a,
  output logic              valid_b
);

  // One extra bit so DEPTH itself is representable for the range check.
  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

  logic [WIDTH-1:0] entry [DEPTH];
  logic [DEPTH-1:0] flag;

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    if (ZERO_REG != 0 && i == ZERO_ADDR) begin : g_zero
      assign entry[i] = '0;
      assign flag[i]  = 1'b0;
    end else begin : g_cell
      reg_file_cell #(
        .WIDTH(WIDTH)
      ) u_cell (
        .clock  (clock),
        .reset  (reset),
        .write  (write && (waddr == ADDR_W'(i))),
        .wdata  (wdata),
        .data   (entry[i]),
        .written(flag[i])
      );
    end
  end

  for (genvar p = 0; p < 2; p++) begin : g_read
    logic [ADDR_W-1:0] addr;
    logic [WIDTH-1:0]  data;
    logic              valid;

    assign addr = (p == 0) ? raddr_a : raddr_b;

    // Zero-register and out-of-range rules are resolved before any forwarding.
    always_comb begin
      data  = '0;
      valid = 1'b0;
      if (ZERO_REG != 0 && addr == ADDR_W'(ZERO_ADDR)) begin
        valid = 1'b1;
      end else if ({1'b0, addr} < DEPTH_W) begin
        data  = entry[addr];
        valid = flag[addr];
`ifdef REG_FILE_BYPASS_EN
        if (write && reset && (waddr == addr)) begin
          data  = wdata;
          valid = 1'b1;
        end
`endif
      end
    end
  end

  assign rdata_a = g_read[0].data;
  assign valid_a = g_read[0].valid;
  assign rdata_b = g_read[1].data;
  assign valid_b = g_read[1].valid;

endmodule

// File: tb/tb_reg_file.sv
// Bench for reg_file: a default instance (DEPTH=16, ZERO_REG=1) and a
// DEPTH=12, ZERO_REG=0 instance share stimulus; expectations go through a queue.
module tb_reg_file;
  import reg_file_pkg::*;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       write = 1'b0;
  logic [3:0] waddr = '0;
  logic [3:0] raddr_a = '0;
  logic [3:0] raddr_b = '0;
  word_t      wdata = '0;

  word_t rdata_a0, rdata_b0, rdata_a1, rdata_b1;
  logic  valid_a0, valid_b0, valid_a1, valid_b1;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [3:0]  addr_a;
    logic [3:0]  addr_b;
    logic [16:0] ea0;
    logic [16:0] eb0;
    logic [16:0] ea1;
    logic [16:0] eb1;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  logic [67:0] got;

  word_t       m_data [2][16];
  logic [15:0] m_flag [2];

  reg_file u_dut (
    .clock  (clock),
    .reset  (reset),
    .write  (write),
    .waddr  (waddr),
    .wdata  (wdata),
    .raddr_a(raddr_a),
    .raddr_b(raddr_b),
    .rdata_a(rdata_a0),
    .rdata_b(rdata_b0),
    .valid_a(valid_a0),
    .valid_b(valid_b0)
  );

  reg_file #(
    .DEPTH   (12),
    .ZERO_REG(0)
  ) u_dut_nz (
    .clock  (clock),
    .reset  (reset),
    .write  (write),
    .waddr  (waddr),
    .wdata  (wdata),
    .raddr_a(raddr_a),
    .raddr_b(raddr_b),
    .rdata_a(rdata_a1),
    .rdata_b(rdata_b1),
    .valid_a(valid_a1),
    .valid_b(valid_b1)
  );

  always #5 clock = ~clock;

  function automatic int depth_of(input int inst);
    return (inst == 0) ? 16 : 12;
  endfunction

  // Expected {valid, data} of one read port of instance inst at address a.
  function automatic logic [16:0] mexp(input int inst, input logic [3:0] a);
    if (inst == 0 && a == 4'd0) return {1'b1, 16'h0000};
    if (int'(a) >= depth_of(inst)) return 17'h0;
`ifdef REG_FILE_BYPASS_EN
    if (write && reset && waddr == a) return {1'b1, wdata};
`endif
    return {m_flag[inst][a], m_data[inst][a]};
  endfunction

  task automatic tick();
    @(posedge clock);
    for (int i = 0; i < 2; i++) begin
      if (!reset) begin
        for (int a = 0; a < 16; a++) m_data[i][a] = '0;
        m_flag[i] = '0;
      end else if (write && int'(waddr) < depth_of(i) && !(i == 0 && waddr == 4'd0)) begin
        m_data[i][waddr] = wdata;
        m_flag[i][waddr] = 1'b1;
      end
    end
    #1;
  endtask

  task automatic push_model(input logic [3:0] aa, input logic [3:0] ab);
    sb.push_back('{aa, ab, mexp(0, aa), mexp(0, ab), mexp(1, aa), mexp(1, ab)});
  endtask

  task automatic push_const(input logic [3:0] aa, input logic [3:0] ab,
                            input logic [16:0] ea0, input logic [16:0] eb0,
                            input logic [16:0] ea1, input logic [16:0] eb1);
    sb.push_back('{aa, ab, ea0, eb0, ea1, eb1});
  endtask

  task automatic test_reset();
    reset = 1'b0;
    write = 1'b0;
    tick();
    tick();
    for (int a = 0; a < 16; a++)
      push_const(4'(a), 4'(15 - a),
                 (a == 0) ? {1'b1, 16'h0} : 17'h0, (a == 15) ? {1'b1, 16'h0} : 17'h0,
                 17'h0, 17'h0);
    reset = 1'b1;
    write = 1'b1;
    wdata = 16'hA5A5;
    for (int a = 1; a < 16; a++) begin
      waddr = 4'(a);
      tick();
    end
    reset = 1'b0;
    waddr = 4'd3;
    wdata = 16'h1234;
    tick();
    reset = 1'b1;
    write = 1'b0;
    for (int a = 0; a < 16; a++)
      push_const(4'(a), 4'(a),
                 (a == 0) ? {1'b1, 16'h0} : 17'h0, (a == 0) ? {1'b1, 16'h0} : 17'h0,
                 17'h0, 17'h0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      raddr_a = e.addr_a;
      raddr_b = e.addr_b;
      @(negedge clock);
      got = {valid_a0, rdata_a0, valid_b0, rdata_b0, valid_a1, rdata_a1, valid_b1, rdata_b1};
      checks++;
      if (got !== {e.ea0, e.eb0, e.ea1, e.eb1}) begin
        failures++;
        $display("FAIL reset a=%0d b=%0d got=%h exp=%h", e.addr_a, e.addr_b, got,
                 {e.ea0, e.eb0, e.ea1, e.eb1});
      end
    end
  endtask

  task automatic test_basic();
    write = 1'b1;
    waddr = 4'd5;
    wdata = 16'h000F;
    tick();
    waddr = 4'd9;
    wdata = 16'hBEEF;
    tick();
    write = 1'b0;
    push_const(4'd5, 4'd9, {1'b1, 16'h000F}, {1'b1, 16'hBEEF}, {1'b1, 16'h000F}, {1'b1, 16'hBEEF});
    push_const(4'd9, 4'd9, {1'b1, 16'hBEEF}, {1'b1, 16'hBEEF}, {1'b1, 16'hBEEF}, {1'b1, 16'hBEEF});
    while (sb.size() > 0) begin
      e = sb.pop_front();
      raddr_a = e.addr_a;
      raddr_b = e.addr_b;
      @(negedge clock);
      got = {valid_a0, rdata_a0, valid_b0, rdata_b0, valid_a1, rdata_a1, valid_b1, rdata_b1};
      checks++;
      if (got !== {e.ea0, e.eb0, e.ea1, e.eb1}) begin
        failures++;
        $display("FAIL basic a=%0d b=%0d got=%h exp=%h", e.addr_a, e.addr_b, got,
                 {e.ea0, e.eb0, e.ea1, e.eb1});
      end
    end
  endtask

  task automatic test_write_disable();
    write = 1'b0;
    waddr = 4'd5;
    wdata = 16'hFFFF;
    tick();
    push_const(4'd5, 4'd5, {1'b1, 16'h000F}, {1'b1, 16'h000F}, {1'b1, 16'h000F}, {1'b1, 16'h000F});
    while (sb.size() > 0) begin
      e = sb.pop_front();
      raddr_a = e.addr_a;
      raddr_b = e.addr_b;
      @(negedge clock);
      got = {valid_a0, rdata_a0, valid_b0, rdata_b0, valid_a1, rdata_a1, valid_b1, rdata_b1};
      checks++;
      if (got !== {e.ea0, e.eb0, e.ea1, e.eb1}) begin
        failures++;
        $display("FAIL write_disable a=%0d b=%0d got=%h exp=%h", e.addr_a, e.addr_b, got,
                 {e.ea0, e.eb0, e.ea1, e.eb1});
      end
    end
  endtask

  task automatic test_zero_reg();
    write = 1'b1;
    waddr = 4'd0;
    wdata = 16'h7777;
    tick();
    write = 1'b0;
    push_const(4'd0, 4'd0, {1'b1, 16'h0}, {1'b1, 16'h0}, {1'b1, 16'h7777}, {1'b1, 16'h7777});
    while (sb.size() > 0) begin
      e = sb.pop_front();
      raddr_a = e.addr_a;
      raddr_b = e.addr_b;
      @(negedge clock);
      got = {valid_a0, rdata_a0, valid_b0, rdata_b0, valid_a1, rdata_a1, valid_b1, rdata_b1};
      checks++;
      if (got !== {e.ea0, e.eb0, e.ea1, e.eb1}) begin
        failures++;
        $display("FAIL zero_reg a=%0d b=%0d got=%h exp=%h", e.addr_a, e.addr_b, got,
                 {e.ea0, e.eb0, e.ea1, e.eb1});
      end
    end
  endtask

  task automatic test_bypass();
    logic [16:0] pre;
`ifdef REG_FILE_BYPASS_EN
    pre = {1'b1, 16'h00C3};
`else
    pre = 17'h0;
`endif
    tick();
    write = 1'b1;
    waddr = 4'd7;
    wdata = 16'h00C3;
    push_const(4'd7, 4'd5, pre, {1'b1, 16'h000F}, pre, {1'b1, 16'h000F});
    while (sb.size() > 0) begin
      e = sb.pop_front();
      raddr_a = e.addr_a;
      raddr_b = e.addr_b;
      @(negedge clock);
      got = {valid_a0, rdata_a0, valid_b0, rdata_b0, valid_a1, rdata_a1, valid_b1, rdata_b1};
      checks++;
      if (got !== {e.ea0, e.eb0, e.ea1, e.eb1}) begin
        failures++;
        $display("FAIL bypass_pre a=%0d b=%0d got=%h exp=%h", e.addr_a, e.addr_b, got,
                 {e.ea0, e.eb0, e.ea1, e.eb1});
      end
    end
    tick();
    write = 1'b0;
    push_const(4'd7, 4'd7, {1'b1, 16'h00C3}, {1'b1, 16'h00C3}, {1'b1, 16'h00C3}, {1'b1, 16'h00C3});
    while (sb.size() > 0) begin
      e = sb.pop_front();
      raddr_a = e.addr_a;
      raddr_b = e.addr_b;
      @(negedge clock);
      got = {valid_a0, rdata_a0, valid_b0, rdata_b0, valid_a1, rdata_a1, valid_b1, rdata_b1};
      checks++;
      if (got !== {e.ea0, e.eb0, e.ea1, e.eb1}) begin
        failures++;
        $display("FAIL bypass_post a=%0d b=%0d got=%h exp=%h", e.addr_a, e.addr_b, got,
                 {e.ea0, e.eb0, e.ea1, e.eb1});
      end
    end
  endtask

  task automatic test_out_of_range();
    write = 1'b1;
    waddr = 4'd13;
    wdata = 16'h5555;
    tick();
    write = 1'b0;
    push_const(4'd5, 4'd13, {1'b1, 16'h000F}, {1'b1, 16'h5555}, {1'b1, 16'h000F}, 17'h0);
    for (int a = 0; a < 16; a++) push_model(4'(a), 4'(a));
    while (sb.size() > 0) begin
      e = sb.pop_front();
      raddr_a = e.addr_a;
      raddr_b = e.addr_b;
      @(negedge clock);
      got = {valid_a0, rdata_a0, valid_b0, rdata_b0, valid_a1, rdata_a1, valid_b1, rdata_b1};
      checks++;
      if (got !== {e.ea0, e.eb0, e.ea1, e.eb1}) begin
        failures++;
        $display("FAIL out_of_range a=%0d b=%0d got=%h exp=%h", e.addr_a, e.addr_b, got,
                 {e.ea0, e.eb0, e.ea1, e.eb1});
      end
    end
  endtask

  task automatic test_back_to_back();
    tick();
    for (int n = 0; n < 60; n++) begin
      reset   = ($urandom_range(0, 15) != 0);
      write   = 1'($urandom_range(0, 1));
      waddr   = 4'($urandom_range(0, 15));
      wdata   = 16'($urandom);
      raddr_a = ($urandom_range(0, 2) == 0) ? waddr : 4'($urandom_range(0, 15));
      raddr_b = 4'($urandom_range(0, 15));
      push_model(raddr_a, raddr_b);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        raddr_a = e.addr_a;
        raddr_b = e.addr_b;
        @(negedge clock);
        got = {valid_a0, rdata_a0, valid_b0, rdata_b0, valid_a1, rdata_a1, valid_b1, rdata_b1};
        checks++;
        if (got !== {e.ea0, e.eb0, e.ea1, e.eb1}) begin
          failures++;
          $display("FAIL back_to_back n=%0d a=%0d b=%0d got=%h exp=%h", n, e.addr_a, e.addr_b,
                   got, {e.ea0, e.eb0, e.ea1, e.eb1});
        end
      end
      tick();
    end
    reset = 1'b1;
    write = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_write_disable();
    test_zero_reg();
    test_bypass();
    test_out_of_range();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
